hazard_scoreboard: RTL and testbench

Register-hazard scoreboard and issue controller for the ID stage of the five-stage LoongArch pipeline. It tracks in-flight register writes between ID issue and WB retire and the subset produced by loads. It drives the ID stage's `ready_go` so that an instruction whose source is an outstanding load result stalls. All other RAW hazards are left to the EX/MEM/WB forwarding network.

---
 rtl/hazard_scoreboard_pkg.sv | 25 ++
 rtl/sb_sat_counter.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the register-hazard scoreboard.
//   SB_NREG       architectural register count (r0 never tracked)
//   SB_REG_IDX_W  register index width
//   SB_CNT_W      per-register outstanding-write counter width
//   SB_EVENT_W    width of a packed {valid, dest} event bus
package hazard_scoreboard_pkg;

    localparam int unsigned SB_NREG      = 32;
    localparam int unsigned SB_REG_IDX_W = 5;
    localparam int unsigned SB_CNT_W     = 2;
    localparam int unsigned SB_EVENT_W   = 1 + SB_REG_IDX_W;

    typedef logic [SB_REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
    } sb_event_t;

    // True when the event targets register r; r0 events never hit anything.
    function automatic logic sb_event_hits(sb_event_t ev, int unsigned r);
        return ev.valid && (ev.dest != '0) && (ev.dest == reg_idx_t'(r));
    endfunction

endpackage

// File: rtl/sb_sat_counter.sv
// Saturating up/down counter for one scoreboard entry.
//   clk, resetn  clock, asynchronous active-low reset
//   clr_i        synchronous clear, beats any same-cycle inc/dec
//   inc_i/dec_i  count up/down; both together leave the count unchanged
//   cnt_o        current count
//   ovf_o        combinational pulse: increment at max or decrement at zero
module sb_sat_counter #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [Width-1:0] CntMax = '1;

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (clr_i) begin
            // Discarded events cannot be in error.
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == CntMax) ovf_o = 1'b1;
            else                 cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) ovf_o = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard and ID issue control.
// Tracks in-flight writes (ID issue -> WB retire) and the load subset whose data
// has not yet come back from MEM. Only load-use hazards stall ID; all other RAW
// hazards are resolved by forwarding.
//   clk, resetn                 clock, asynchronous active-low reset
//   id_*                        instruction held in ID
//   ex_allow_in                 EX can accept
//   id_ready_go, id_fire        issue handshake outputs (combinational)
//   mem_ld_done, mem_ld_dest    load data returned in MEM
//   wb_valid, wb_dest           register write retiring in WB
//   flush                       discard all in-flight work
//   sb_busy                     per-register outstanding-write flag (bit 0 = 0)
//   sb_ovf                      sticky counter over/underflow, cleared by reset only
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREG  = SB_NREG,
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    id_valid,
    input  logic [SB_REG_IDX_W-1:0] id_rj,
    input  logic [SB_REG_IDX_W-1:0] id_rkd,
    input  logic                    id_use_rj,
    input  logic                    id_use_rkd,
    input  logic [SB_REG_IDX_W-1:0] id_dest,
    input  logic                    id_is_load,
    input  logic                    ex_allow_in,
    output logic                    id_ready_go,
    output logic                    id_fire,
    input  logic                    mem_ld_done,
    input  logic [SB_REG_IDX_W-1:0] mem_ld_dest,
    input  logic                    wb_valid,
    input  logic [SB_REG_IDX_W-1:0] wb_dest,
    input  logic                    flush,
    output logic [NREG-1:0]         sb_busy,
    output logic                    sb_ovf
);

    logic [NREG-1:0] wcnt_nz;
    logic [NREG-1:0] wcnt_full;
    logic [NREG-1:0] lcnt_nz;
    logic [NREG-1:1] w_ovf;
    logic [NREG-1:1] l_ovf;

    sb_event_t id_ev, id_ld_ev, mem_ev, wb_ev;

    assign id_ev    = '{valid: id_fire, dest: id_dest};
    assign id_ld_ev = '{valid: id_fire & id_is_load, dest: id_dest};
    assign mem_ev   = '{valid: mem_ld_done, dest: mem_ld_dest};
    assign wb_ev    = '{valid: wb_valid, dest: wb_dest};

    // r0 is hard-wired: never busy, never hazardous.
    assign wcnt_nz[0]   = 1'b0;
    assign wcnt_full[0] = 1'b0;
    assign lcnt_nz[0]   = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CNT_W-1:0] wcnt;
        logic [CNT_W-1:0] lcnt;

        sb_sat_counter #(
            .Width (CNT_W)
        ) u_wcnt (
            .clk    (clk),
            .resetn (resetn),
            .clr_i  (flush),
            .inc_i  (sb_event_hits(id_ev, r)),
            .dec_i  (sb_event_hits(wb_ev, r)),
            .cnt_o  (wcnt),
            .ovf_o  (w_ovf[r])
        );

        sb_sat_counter #(
            .Width (CNT_W)
        ) u_lcnt (
            .clk    (clk),
            .resetn (resetn),
            .clr_i  (flush),
            .inc_i  (sb_event_hits(id_ld_ev, r)),
            .dec_i  (sb_event_hits(mem_ev, r)),
            .cnt_o  (lcnt),
            .ovf_o  (l_ovf[r])
        );

        assign wcnt_nz[r]   = (wcnt != '0);
        assign wcnt_full[r] = &wcnt;
        assign lcnt_nz[r]   = (lcnt != '0);
    end

    logic ld_haz;
    logic cap_haz;

    // No bypass from mem_ld_done: the dependent waits one more cycle and then
    // takes the value from the MEM/WB forwarding path.
    assign ld_haz  = (id_use_rj  && (id_rj  != '0) && lcnt_nz[id_rj]) ||
                     (id_use_rkd && (id_rkd != '0) && lcnt_nz[id_rkd]);
    // A fourth writer would overflow the counter, so hold it in ID.
    assign cap_haz = (id_dest != '0) && wcnt_full[id_dest];

    assign id_ready_go = !id_valid || (!ld_haz && !cap_haz && !flush);
    assign id_fire     = id_valid && id_ready_go && ex_allow_in;

    assign sb_busy = wcnt_nz;

    logic sb_ovf_q, sb_ovf_d;

    assign sb_ovf_d = sb_ovf_q || (|w_ovf) || (|l_ovf);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sb_ovf_q <= 1'b0;
        else         sb_ovf_q <= sb_ovf_d;
    end

    assign sb_ovf = sb_ovf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk, resetn;
    logic       id_valid, id_use_rj, id_use_rkd, id_is_load, ex_allow_in;
    logic [4:0] id_rj, id_rkd, id_dest, mem_ld_dest, wb_dest;
    logic       mem_ld_done, wb_valid, flush;
    logic       id_ready_go, id_fire, sb_ovf;
    logic [31:0] sb_busy;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding write / pending load counts per register.
    int m_wcnt[32];
    int m_lcnt[32];
    bit m_ovf;

    hazard_scoreboard dut (
        .clk         (clk),
        .resetn      (resetn),
        .id_valid    (id_valid),
        .id_rj       (id_rj),
        .id_rkd      (id_rkd),
        .id_use_rj   (id_use_rj),
        .id_use_rkd  (id_use_rkd),
        .id_dest     (id_dest),
        .id_is_load  (id_is_load),
        .ex_allow_in (ex_allow_in),
        .id_ready_go (id_ready_go),
        .id_fire     (id_fire),
        .mem_ld_done (mem_ld_done),
        .mem_ld_dest (mem_ld_dest),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .flush       (flush),
        .sb_busy     (sb_busy),
        .sb_ovf      (sb_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void m_clear();
        for (int r = 0; r < 32; r++) begin
            m_wcnt[r] = 0;
            m_lcnt[r] = 0;
        end
    endfunction

    function automatic bit m_ready();
        bit ld, cap;
        ld  = (id_use_rj  && id_rj  != 0 && m_lcnt[id_rj]  > 0) ||
              (id_use_rkd && id_rkd != 0 && m_lcnt[id_rkd] > 0);
        cap = (id_dest != 0) && (m_wcnt[id_dest] >= 3);
        return !id_valid || (!ld && !cap && !flush);
    endfunction

    function automatic bit m_fire();
        return id_valid && m_ready() && ex_allow_in;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (m_wcnt[r] > 0);
        return v;
    endfunction

    function automatic int sat(int c, bit inc, bit dec);
        if (inc && !dec) begin
            if (c == 3) begin m_ovf = 1'b1; return c; end
            return c + 1;
        end
        if (dec && !inc) begin
            if (c == 0) begin m_ovf = 1'b1; return c; end
            return c - 1;
        end
        return c;
    endfunction

    // Apply one clock edge to the model using the inputs present before the edge.
    function automatic void m_step();
        bit f;
        f = m_fire();
        if (flush) begin
            m_clear();
            return;
        end
        for (int r = 1; r < 32; r++) begin
            m_wcnt[r] = sat(m_wcnt[r], f && id_dest == r, wb_valid && wb_dest == r);
            m_lcnt[r] = sat(m_lcnt[r], f && id_is_load && id_dest == r,
                            mem_ld_done && mem_ld_dest == r);
        end
    endfunction

    task automatic idle();
        id_valid = 0; id_use_rj = 0; id_use_rkd = 0; id_is_load = 0;
        id_rj = 0; id_rkd = 0; id_dest = 0; ex_allow_in = 1;
        mem_ld_done = 0; mem_ld_dest = 0; wb_valid = 0; wb_dest = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        m_clear();
        m_ovf = 0;
        #3;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", id_ready_go); end
        total++; if (id_fire !== 1'b0) begin bad++; $display("FAIL reset_fire got=%b want=0", id_fire); end
        total++; if (sb_busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", sb_busy); end
        total++; if (sb_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", sb_ovf); end
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1; id_dest = 5; id_is_load = 1;
        #3;
        total++; if (id_fire !== 1'b1) begin bad++; $display("FAIL lu_ld_fire got=%b want=1", id_fire); end
        tick();
        id_is_load = 0; id_dest = 6; id_rj = 5; id_use_rj = 1;
        #3;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL lu_stall_ex got=%b want=0", id_ready_go); end
        total++; if (sb_busy[5] !== 1'b1) begin bad++; $display("FAIL lu_busy5 got=%b want=1", sb_busy[5]); end
        tick();
        mem_ld_done = 1; mem_ld_dest = 5;
        #3;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL lu_stall_done got=%b want=0", id_ready_go); end
        tick();
        mem_ld_done = 0;
        #3;
        total++; if ({id_ready_go, id_fire} !== 2'b11) begin bad++; $display("FAIL lu_release got=%b want=11", {id_ready_go, id_fire}); end
        tick();
        idle();
        wb_valid = 1; wb_dest = 5;
        tick();
        wb_dest = 6;
        tick();
        wb_valid = 0;
        #3;
        total++; if (sb_busy !== 32'h0) begin bad++; $display("FAIL lu_drained got=%h want=0", sb_busy); end
    endtask

    task automatic test_raw_nonload();
        idle();
        id_valid = 1; id_dest = 7;
        tick();
        id_dest = 8; id_rj = 7; id_use_rj = 1; id_rkd = 7; id_use_rkd = 1;
        #3;
        total++; if ({id_ready_go, id_fire} !== 2'b11) begin bad++; $display("FAIL raw_nostall got=%b want=11", {id_ready_go, id_fire}); end
        total++; if (sb_busy[7] !== 1'b1) begin bad++; $display("FAIL raw_busy7 got=%b want=1", sb_busy[7]); end
        tick();
        idle();
        wb_valid = 1; wb_dest = 7;
        #3;
        total++; if (sb_busy[7] !== 1'b1) begin bad++; $display("FAIL raw_busy7_wb got=%b want=1", sb_busy[7]); end
        tick();
        total++; if (sb_busy !== 32'h0000_0100) begin bad++; $display("FAIL raw_after_wb got=%h want=00000100", sb_busy); end
        wb_dest = 8;
        tick();
        wb_valid = 0;
    endtask

    task automatic test_two_loads();
        idle();
        id_valid = 1; id_dest = 3; id_is_load = 1;
        tick();
        tick();
        id_is_load = 0; id_dest = 10; id_rkd = 3; id_use_rkd = 1;
        mem_ld_done = 1; mem_ld_dest = 3;
        #3;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL ld2_stall_a got=%b want=0", id_ready_go); end
        tick();
        #3;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL ld2_stall_b got=%b want=0", id_ready_go); end
        tick();
        mem_ld_done = 0;
        #3;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL ld2_release got=%b want=1", id_ready_go); end
        id_valid = 0;
        wb_valid = 1; wb_dest = 3;
        tick();
        tick();
        wb_valid = 0;
        #3;
        total++; if (sb_busy[3] !== 1'b0) begin bad++; $display("FAIL ld2_drained got=%b want=0", sb_busy[3]); end
    endtask

    task automatic test_same_cycle();
        idle();
        id_valid = 1; id_dest = 9;
        tick();
        wb_valid = 1; wb_dest = 9;
        tick();
        wb_valid = 0;
        total++; if (sb_busy[9] !== 1'b1) begin bad++; $display("FAIL same_cycle_busy got=%b want=1", sb_busy[9]); end
        tick();
        tick();
        #3;
        total++; if ({id_ready_go, id_fire} !== 2'b00) begin bad++; $display("FAIL cap_stall got=%b want=00", {id_ready_go, id_fire}); end
        id_valid = 0;
        wb_valid = 1;
        tick();
        #3;
        total++; if (sb_busy[9] !== 1'b1) begin bad++; $display("FAIL cap_busy9 got=%b want=1", sb_busy[9]); end
        tick();
        tick();
        wb_valid = 0;
        total++; if (sb_busy[9] !== 1'b0 || sb_ovf !== 1'b0) begin bad++; $display("FAIL cap_drained got=%b%b want=00", sb_busy[9], sb_ovf); end
    endtask

    task automatic test_flush_ovf();
        idle();
        id_valid = 1; id_dest = 4; id_is_load = 1;
        tick();
        id_is_load = 0; id_dest = 0; id_rj = 4; id_use_rj = 1; flush = 1;
        #3;
        total++; if (id_fire !== 1'b0) begin bad++; $display("FAIL flush_nofire got=%b want=0", id_fire); end
        tick();
        flush = 0;
        #3;
        total++; if (sb_busy !== 32'h0) begin bad++; $display("FAIL flush_busy got=%h want=0", sb_busy); end
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", id_ready_go); end
        tick();
        idle();
        wb_valid = 1; wb_dest = 4;
        tick();
        wb_valid = 0;
        total++; if (sb_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", sb_ovf); end
        flush = 1;
        tick();
        flush = 0;
        tick();
        total++; if (sb_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", sb_ovf); end
    endtask

    task automatic test_reset_midstall();
        idle();
        id_valid = 1; id_dest = 5; id_is_load = 1;
        tick();
        id_is_load = 0; id_dest = 0; id_rj = 5; id_use_rj = 1;
        #2;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL rst_pre_stall got=%b want=0", id_ready_go); end
        resetn = 0;
        m_clear();
        m_ovf = 0;
        #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL rst_stall_drop got=%b want=1", id_ready_go); end
        total++; if (sb_busy !== 32'h0 || sb_ovf !== 1'b0) begin bad++; $display("FAIL rst_async_state got=%h/%b want=0/0", sb_busy, sb_ovf); end
        id_valid = 0;
        #1;
        total++; if (id_fire !== 1'b0) begin bad++; $display("FAIL rst_fire got=%b want=0", id_fire); end
        resetn = 1;
        idle();
        @(posedge clk);
        #1;
    endtask

    // Pick a register (1..4) with outstanding work so retire events stay plausible.
    function automatic int pick(bit load);
        int s;
        s = $urandom_range(1, 4);
        for (int k = 0; k < 4; k++) begin
            int r;
            r = 1 + ((s - 1 + k) % 4);
            if ((load ? m_lcnt[r] : m_wcnt[r]) > 0) return r;
        end
        return 0;
    endfunction

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rj       = 5'($urandom_range(0, 4));
            id_rkd      = 5'($urandom_range(0, 4));
            id_use_rj   = $urandom_range(0, 1) == 1;
            id_use_rkd  = $urandom_range(0, 1) == 1;
            id_dest     = 5'($urandom_range(0, 4));
            id_is_load  = $urandom_range(0, 1) == 1;
            ex_allow_in = ($urandom_range(0, 3) != 0);
            mem_ld_done = ($urandom_range(0, 2) == 0);
            mem_ld_dest = ($urandom_range(0, 40) == 0) ? 5'($urandom_range(0, 4)) : 5'(pick(1));
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_dest     = ($urandom_range(0, 40) == 0) ? 5'($urandom_range(0, 4)) : 5'(pick(0));
            flush       = ($urandom_range(0, 19) == 0);
            #3;
            total++; if (id_ready_go !== m_ready()) begin bad++; $display("FAIL rnd_ready i=%0d got=%b want=%b", i, id_ready_go, m_ready()); end
            total++; if (id_fire !== m_fire()) begin bad++; $display("FAIL rnd_fire i=%0d got=%b want=%b", i, id_fire, m_fire()); end
            tick();
            total++; if (sb_busy !== m_busy()) begin bad++; $display("FAIL rnd_busy i=%0d got=%h want=%h", i, sb_busy, m_busy()); end
            total++; if (sb_ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf i=%0d got=%b want=%b", i, sb_ovf, m_ovf); end
        end
        idle();
    endtask

    initial begin
        resetn = 0;
        idle();
        test_reset();
        test_load_use();
        test_raw_nonload();
        test_two_loads();
        test_same_cycle();
        test_flush_ovf();
        test_reset_midstall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
